// File: rtl/i2c_pkg.sv
// ----------------------------------------------------------------------------
// i2c_pkg
//   Shared types and constants for the I2C target register interface.
//   - state_t   : one-hot FSM encoding of the byte/ACK phases
//   - bus_ev_t  : START / STOP event codes from the line detectors
//   - DEV_ADDR_DEFAULT : SD30xx 7-bit device address
//   - addr_inc  : register pointer increment with 8/16-bit wrap
// ----------------------------------------------------------------------------
package i2c_pkg;

    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h32;

    typedef enum logic [9:0] {
        ST_IDLE     = 10'b00_0000_0001,
        ST_DEV_ADDR = 10'b00_0000_0010,
        ST_DEV_ACK  = 10'b00_0000_0100,
        ST_PTR_H    = 10'b00_0000_1000,
        ST_PTR_L    = 10'b00_0001_0000,
        ST_PTR_ACK  = 10'b00_0010_0000,
        ST_WR_DATA  = 10'b00_0100_0000,
        ST_WR_ACK   = 10'b00_1000_0000,
        ST_RD_DATA  = 10'b01_0000_0000,
        ST_RD_ACK   = 10'b10_0000_0000
    } state_t;

    typedef enum logic [1:0] {
        EV_NONE  = 2'd0,
        EV_START = 2'd1,
        EV_STOP  = 2'd2
    } bus_ev_t;

    // 8-bit mode keeps the upper pointer byte at zero and wraps 0xFF -> 0x00.
    function automatic logic [15:0] addr_inc(input logic [15:0] addr, input logic mode16);
        logic [7:0] lo_next;
        lo_next = addr[7:0] + 8'd1;
        return mode16 ? (addr + 16'd1) : {8'h00, lo_next};
    endfunction

endpackage

// File: rtl/i2c_slave_regif_line_sync.sv
// ----------------------------------------------------------------------------
// i2c_line_sync
//   Synchronizer for one I2C pad line, optional glitch filter, edge detect.
//   Ports:
//     clk, rst : system clock, async active-high reset
//     pad      : raw line from the pad
//     level    : synchronized (and filtered) line level
//     rise     : one-clk flag on a 0->1 transition of level
//     fall     : one-clk flag on a 1->0 transition of level
//   Macro I2C_GLITCH_FILTER_EN: when defined, level only follows the synced
//   line after three equal consecutive samples (pulses < 3 clk are dropped).
// ----------------------------------------------------------------------------
module i2c_line_sync #(
    parameter int SYNC_STG = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pad,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STG-1:0] sync_q;
    logic                level_q;

    // Idle I2C bus is high, so reset the chain to 1 to avoid a false edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '1;
        else     sync_q <= {sync_q[SYNC_STG-2:0], pad};
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [1:0] hist_q;
    logic       sync_out;

    assign sync_out = sync_q[SYNC_STG-1];
    // Current sample plus the two previous ones must agree before level moves.
    assign level = (hist_q == {2{sync_out}}) ? sync_out : level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) hist_q <= 2'b11;
        else     hist_q <= {hist_q[0], sync_out};
    end
`else
    assign level = sync_q[SYNC_STG-1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) level_q <= 1'b1;
        else     level_q <= level;
    end

    assign rise = level & ~level_q;
    assign fall = ~level & level_q;

endmodule

// File: rtl/i2c_slave_regif.sv
// ----------------------------------------------------------------------------
// i2c_slave_regif
//   I2C target: START/STOP decode, 7-bit address match, 8/16-bit register
//   pointer, then byte writes or reads on a parallel register bus.
//   Open-drain SDA only; SCL is never driven.
//   Ports:
//     clk, rst   : system clock (>= 16x SCL), async active-high reset
//     addr_mode  : 1 = 16-bit pointer (MSB first), 0 = 8-bit pointer
//     scl_i/sda_i: pad inputs
//     sda_oe     : 1 = pull SDA low
//     reg_addr   : register pointer
//     wr_en/wr_data : one-clk write strobe and byte
//     rd_en/rd_data : one-clk read strobe; rd_data sampled 1 clk after rd_en
//     busy       : addressed and active
//   Macro I2C_GLITCH_FILTER_EN: enables the line glitch filter in i2c_line_sync.
//
//   state       | meaning
//   ------------+--------------------------------------------------------
//   ST_IDLE     | not addressed; wait for START (also after read NACK)
//   ST_DEV_ADDR | shifting in the address byte
//   ST_DEV_ACK  | ACK of address byte; read strobe issued on entry for R/W=1
//   ST_PTR_H    | receiving pointer high byte (16-bit mode)
//   ST_PTR_L    | receiving pointer low byte
//   ST_PTR_ACK  | ACK of a pointer byte
//   ST_WR_DATA  | receiving a write data byte
//   ST_WR_ACK   | ACK of a write data byte
//   ST_RD_DATA  | shifting out a read byte
//   ST_RD_ACK   | sampling master ACK/NACK of a read byte
// ----------------------------------------------------------------------------
module i2c_slave_regif
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT,
    parameter int         SYNC_STG = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        addr_mode,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    output logic [15:0] reg_addr,
    output logic        wr_en,
    output logic [7:0]  wr_data,
    output logic        rd_en,
    input  logic [7:0]  rd_data,
    output logic        busy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_sync #(.SYNC_STG(SYNC_STG)) u_scl_sync (
        .clk(clk), .rst(rst), .pad(scl_i),
        .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_line_sync #(.SYNC_STG(SYNC_STG)) u_sda_sync (
        .clk(clk), .rst(rst), .pad(sda_i),
        .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
    );

    state_t      state_q, state_d;
    bus_ev_t     bus_ev;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d, ptr_hi_q, ptr_hi_d;
    logic        rw_q, rw_d, ptr_lo_done_q, ptr_lo_done_d, rd_pend_q;
    logic        sda_oe_d, busy_d, wr_en_d, rd_en_d;
    logic [15:0] reg_addr_d;
    logic [7:0]  wr_data_d, rx_byte;

    assign rx_byte = {shift_q[6:0], sda_lvl};

    always_comb begin
        bus_ev = EV_NONE;
        if (scl_lvl && sda_fall)      bus_ev = EV_START;
        else if (scl_lvl && sda_rise) bus_ev = EV_STOP;
    end

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        ptr_hi_d      = ptr_hi_q;
        rw_d          = rw_q;
        ptr_lo_done_d = ptr_lo_done_q;
        sda_oe_d      = sda_oe;
        busy_d        = busy;
        reg_addr_d    = reg_addr;
        wr_data_d     = wr_data;
        wr_en_d       = 1'b0;
        rd_en_d       = 1'b0;

        // Pointer advances in the cycle after the write strobe.
        if (wr_en)     reg_addr_d = addr_inc(reg_addr, addr_mode);
        if (rd_pend_q) shift_d    = rd_data;

        if (bus_ev == EV_START) begin
            state_d   = ST_DEV_ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (bus_ev == EV_STOP) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_DEV_ADDR, ST_PTR_H, ST_PTR_L, ST_WR_DATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            if (state_q == ST_DEV_ADDR) begin
                                if (rx_byte[7:1] == DEV_ADDR) begin
                                    state_d = ST_DEV_ACK;
                                    busy_d  = 1'b1;
                                    rw_d    = rx_byte[0];
                                    rd_en_d = rx_byte[0];
                                end else begin
                                    state_d = ST_IDLE;
                                end
                            end else if (state_q == ST_PTR_H) begin
                                ptr_hi_d = rx_byte;
                                state_d  = ST_PTR_ACK;
                            end else if (state_q == ST_PTR_L) begin
                                reg_addr_d    = {addr_mode ? ptr_hi_q : 8'h00, rx_byte};
                                ptr_lo_done_d = 1'b1;
                                state_d       = ST_PTR_ACK;
                            end else begin
                                wr_en_d   = 1'b1;
                                wr_data_d = rx_byte;
                                state_d   = ST_WR_ACK;
                            end
                        end
                    end
                end
                // bit_cnt 0 = before the ACK clock, 1 = ACK clock has risen.
                ST_DEV_ACK, ST_PTR_ACK, ST_WR_ACK: begin
                    if (scl_rise) begin
                        bit_cnt_d = 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd0) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            bit_cnt_d = 4'd0;
                            sda_oe_d  = 1'b0;
                            if (state_q == ST_DEV_ACK && rw_q) begin
                                sda_oe_d = ~shift_q[7];
                                state_d  = ST_RD_DATA;
                            end else if (state_q == ST_DEV_ACK) begin
                                ptr_lo_done_d = 1'b0;
                                state_d       = addr_mode ? ST_PTR_H : ST_PTR_L;
                            end else if (state_q == ST_PTR_ACK && !ptr_lo_done_q) begin
                                state_d = ST_PTR_L;
                            end else begin
                                state_d = ST_WR_DATA;
                            end
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            bit_cnt_d = 4'd0;
                            sda_oe_d  = 1'b0;
                            state_d   = ST_RD_ACK;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_lvl) begin
                            state_d = ST_IDLE;
                        end else begin
                            bit_cnt_d  = 4'd1;
                            reg_addr_d = addr_inc(reg_addr, addr_mode);
                            rd_en_d    = 1'b1;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd1) begin
                        bit_cnt_d = 4'd0;
                        sda_oe_d  = ~shift_q[7];
                        state_d   = ST_RD_DATA;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= 4'd0;
            shift_q       <= 8'h00;
            ptr_hi_q      <= 8'h00;
            rw_q          <= 1'b0;
            ptr_lo_done_q <= 1'b0;
            rd_pend_q     <= 1'b0;
            sda_oe        <= 1'b0;
            busy          <= 1'b0;
            reg_addr      <= 16'h0000;
            wr_data       <= 8'h00;
            wr_en         <= 1'b0;
            rd_en         <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            ptr_hi_q      <= ptr_hi_d;
            rw_q          <= rw_d;
            ptr_lo_done_q <= ptr_lo_done_d;
            rd_pend_q     <= rd_en;
            sda_oe        <= sda_oe_d;
            busy          <= busy_d;
            reg_addr      <= reg_addr_d;
            wr_data       <= wr_data_d;
            wr_en         <= wr_en_d;
            rd_en         <= rd_en_d;
        end
    end

endmodule

// File: tb/tb_i2c_slave_regif.sv
module tb_i2c_slave_regif;

    localparam int Q = 20;   // clk cycles per quarter SCL period

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        addr_mode = 1'b0;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_bus;
    logic        sda_oe, wr_en, rd_en, busy;
    logic [15:0] reg_addr;
    logic [7:0]  wr_data;
    logic [7:0]  rd_data = 8'h00;

    int vec_cnt = 0;
    int err_cnt = 0;
    int wr_seen = 0, rd_seen = 0, exp_wr_total = 0, exp_rd_total = 0;
    logic [23:0] exp_wr_q[$];
    logic [15:0] exp_rd_q[$];

    assign sda_bus = sda_m & ~sda_oe;

    always #10 clk = ~clk;

    i2c_slave_regif dut (
        .clk(clk), .rst(rst), .addr_mode(addr_mode),
        .scl_i(scl_m), .sda_i(sda_bus), .sda_oe(sda_oe),
        .reg_addr(reg_addr), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .busy(busy)
    );

    function automatic logic [7:0] model_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Register-file model: registered read data one clk after rd_en.
    always @(posedge clk) if (rd_en) rd_data <= model_byte(reg_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && wr_en) begin
            wr_seen++;
            if (exp_wr_q.size() != 0) check("wr_addr_data", {8'h00, reg_addr, wr_data}, {8'h00, exp_wr_q.pop_front()});
        end
        if (!rst && rd_en) begin
            rd_seen++;
            if (exp_rd_q.size() != 0) check("rd_addr", {16'h0, reg_addr}, {16'h0, exp_rd_q.pop_front()});
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b1; wait_clk(Q);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    wait_clk(Q);
        scl_m = 1'b1; wait_clk(2 * Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        b = sda_bus;  wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(ack);
    endtask

    task automatic wr_txn(input string tag, input logic mode16, input logic [15:0] ptr,
                          input int n, input logic [7:0] d0, input logic [7:0] d1);
        logic        ack;
        logic [7:0]  d;
        logic [15:0] a;
        a = mode16 ? ptr : {8'h00, ptr[7:0]};
        addr_mode = mode16;
        i2c_start();
        send_byte(8'h64, ack);
        check({tag, "_dev_ack"}, {31'h0, ack}, 32'h0);
        check({tag, "_busy_on"}, {31'h0, busy}, 32'h1);
        if (mode16) begin
            send_byte(ptr[15:8], ack);
            check({tag, "_ptrh_ack"}, {31'h0, ack}, 32'h0);
        end
        send_byte(ptr[7:0], ack);
        check({tag, "_ptrl_ack"}, {31'h0, ack}, 32'h0);
        for (int i = 0; i < n; i++) begin
            d = (i == 0) ? d0 : d1;
            exp_wr_q.push_back({a, d});
            exp_wr_total++;
            send_byte(d, ack);
            check({tag, "_data_ack"}, {31'h0, ack}, 32'h0);
            a = mode16 ? a + 16'd1 : {8'h00, a[7:0] + 8'd1};
        end
        i2c_stop();
        check({tag, "_busy_off"}, {31'h0, busy}, 32'h0);
        check({tag, "_reg_addr"}, {16'h0, reg_addr}, {16'h0, a});
        check({tag, "_wr_count"}, wr_seen, exp_wr_total);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack;
        logic [7:0] d;

        wait_clk(3);
        check("rst_sda_oe",   {31'h0, sda_oe}, 32'h0);
        check("rst_busy",     {31'h0, busy},   32'h0);
        check("rst_wr_en",    {31'h0, wr_en},  32'h0);
        check("rst_rd_en",    {31'h0, rd_en},  32'h0);
        check("rst_reg_addr", {16'h0, reg_addr}, 32'h0);
        check("rst_wr_data",  {24'h0, wr_data},  32'h0);
        rst = 1'b0;
        wait_clk(Q);

        // 8-bit write
        wr_txn("t1", 1'b0, 16'h0005, 1, 8'hA5, 8'h00);

        // 16-bit pointer, repeated START, two-byte read
        addr_mode = 1'b1;
        i2c_start();
        send_byte(8'h64, ack); check("t2_dev_ack", {31'h0, ack}, 32'h0);
        send_byte(8'h01, ack); check("t2_ptrh_ack", {31'h0, ack}, 32'h0);
        send_byte(8'h02, ack); check("t2_ptrl_ack", {31'h0, ack}, 32'h0);
        exp_rd_q.push_back(16'h0102); exp_rd_total++;
        exp_rd_q.push_back(16'h0103); exp_rd_total++;
        i2c_start();
        send_byte(8'h65, ack); check("t2_rd_dev_ack", {31'h0, ack}, 32'h0);
        recv_byte(d, 1'b0);    check("t2_byte0", {24'h0, d}, {24'h0, model_byte(16'h0102)});
        recv_byte(d, 1'b1);    check("t2_byte1", {24'h0, d}, {24'h0, model_byte(16'h0103)});
        check("t2_sda_rel", {31'h0, sda_oe}, 32'h0);
        i2c_stop();
        check("t2_busy_off", {31'h0, busy}, 32'h0);
        check("t2_reg_addr", {16'h0, reg_addr}, 32'h0103);
        check("t2_rd_count", rd_seen, exp_rd_total);

        // address mismatch
        addr_mode = 1'b0;
        i2c_start();
        send_byte(8'h66, ack); check("t3_nack", {31'h0, ack}, 32'h1);
        check("t3_busy", {31'h0, busy}, 32'h0);
        i2c_stop();
        check("t3_wr_count", wr_seen, exp_wr_total);
        check("t3_rd_count", rd_seen, exp_rd_total);

        // abort after four data bits
        i2c_start();
        send_byte(8'h64, ack); check("t4_dev_ack", {31'h0, ack}, 32'h0);
        send_byte(8'h10, ack); check("t4_ptr_ack", {31'h0, ack}, 32'h0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        i2c_stop();
        check("t4_sda_oe",   {31'h0, sda_oe}, 32'h0);
        check("t4_busy",     {31'h0, busy},   32'h0);
        check("t4_reg_addr", {16'h0, reg_addr}, 32'h0010);
        check("t4_wr_count", wr_seen, exp_wr_total);
        wr_txn("t4b", 1'b0, 16'h0020, 1, 8'h3C, 8'h00);

        // pointer wrap, 8-bit then 16-bit
        wr_txn("t5", 1'b0, 16'h00FF, 2, 8'h11, 8'h22);
        wr_txn("t5b", 1'b1, 16'hFFFF, 1, 8'h33, 8'h00);

        // reset while driving read data (model byte at 0x40 has MSB 0)
        addr_mode = 1'b0;
        i2c_start();
        send_byte(8'h64, ack); check("t6_dev_ack", {31'h0, ack}, 32'h0);
        send_byte(8'h40, ack); check("t6_ptr_ack", {31'h0, ack}, 32'h0);
        exp_rd_q.push_back(16'h0040); exp_rd_total++;
        i2c_start();
        send_byte(8'h65, ack); check("t6_rd_dev_ack", {31'h0, ack}, 32'h0);
        check("t6_drive_msb", {31'h0, sda_oe}, 32'h1);
        @(posedge clk);
        #5 rst = 1'b1;
        #1 check("t6_async_sda_oe", {31'h0, sda_oe}, 32'h0);
        check("t6_rst_busy", {31'h0, busy}, 32'h0);
        check("t6_rst_reg_addr", {16'h0, reg_addr}, 32'h0);
        check("t6_rd_count", rd_seen, exp_rd_total);
        wait_clk(4);
        scl_m = 1'b1;
        sda_m = 1'b1;
        rst = 1'b0;
        wait_clk(Q);

`ifdef I2C_GLITCH_FILTER_EN
        // 2-clk SCL glitch in the low phase must not add a bit
        i2c_start();
        send_byte(8'h64, ack); check("t6g_dev_ack", {31'h0, ack}, 32'h0);
        send_byte(8'h08, ack); check("t6g_ptr_ack", {31'h0, ack}, 32'h0);
        wait_clk(2);
        scl_m = 1'b1; wait_clk(2);
        scl_m = 1'b0; wait_clk(Q);
        exp_wr_q.push_back({16'h0008, 8'h5A}); exp_wr_total++;
        send_byte(8'h5A, ack); check("t6g_data_ack", {31'h0, ack}, 32'h0);
        i2c_stop();
        check("t6g_wr_count", wr_seen, exp_wr_total);
`endif

        wr_txn("t6b", 1'b0, 16'h0007, 1, 8'h99, 8'h00);

        check("end_wr_q_empty", exp_wr_q.size(), 32'h0);
        check("end_rd_q_empty", exp_rd_q.size(), 32'h0);
        check("end_rd_count", rd_seen, exp_rd_total);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
